// File: rtl/h264_feed_sched_pkg.sv
// Shared types and geometry constants for the H.264 raw-frame feed scheduler.
// The FSM state encoding is visible on the fsm_state debug output.
package h264_feed_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_FLUSH = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int MB_DIM       = 16;
  localparam int BLK_DIM      = 4;
  localparam int ROWS_PER_BLK = 4;

  // A frame dimension is usable when it is a nonzero whole number of macroblocks.
  function automatic logic dim_ok(input logic [11:0] d);
    return (d != 12'd0) && (d[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/h264_addr_gen.sv
// Raster walker over macroblocks / 4x4 blocks / rows, producing the byte address
// of the next word to read. addr is registered and always reflects the counters.
module h264_addr_gen
  import h264_feed_sched_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic              frame_next,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [11:0]       cfg_width,
  input  logic [11:0]       cfg_height,
  output logic              last_word,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [1:0] ROW_LAST = 2'(ROWS_PER_BLK - 1);
  localparam logic [1:0] BLK_LAST = 2'(MB_DIM / BLK_DIM - 1);

  logic [11:0]       width_q, height_q;
  logic [ADDR_W-1:0] fbase, n_fbase, n_addr;
  logic [1:0]        row, bx, by, n_row, n_bx, n_by;
  logic [7:0]        mbx, mby, n_mbx, n_mby;
  logic [7:0]        mbx_last, mby_last;
  logic [11:0]       w_use, line;

  assign mbx_last = width_q[11:4] - 8'd1;
  assign mby_last = height_q[11:4] - 8'd1;

  assign last_word = (row == ROW_LAST) && (bx == BLK_LAST) && (by == BLK_LAST) &&
                     (mbx == mbx_last) && (mby == mby_last);

  always_comb begin
    n_fbase = fbase;
    n_row   = row;
    n_bx    = bx;
    n_by    = by;
    n_mbx   = mbx;
    n_mby   = mby;
    // On clear the new geometry is not latched yet, so use it straight from the ports.
    w_use   = clear ? cfg_width : width_q;
    if (clear) begin
      n_fbase = cfg_base;
      n_row   = '0; n_bx = '0; n_by = '0; n_mbx = '0; n_mby = '0;
    end else if (frame_next) begin
      n_fbase = fbase + ADDR_W'(width_q) * ADDR_W'(height_q);
      n_row   = '0; n_bx = '0; n_by = '0; n_mbx = '0; n_mby = '0;
    end else if (inc) begin
      if (row != ROW_LAST) n_row = row + 2'd1;
      else begin
        n_row = '0;
        if (bx != BLK_LAST) n_bx = bx + 2'd1;
        else begin
          n_bx = '0;
          if (by != BLK_LAST) n_by = by + 2'd1;
          else begin
            n_by = '0;
            if (mbx != mbx_last) n_mbx = mbx + 8'd1;
            else begin
              n_mbx = '0;
              n_mby = (mby != mby_last) ? mby + 8'd1 : 8'd0;
            end
          end
        end
      end
    end
    line   = 12'(n_mby) * 12'(MB_DIM) + 12'(n_by) * 12'(BLK_DIM) + 12'(n_row);
    n_addr = n_fbase + ADDR_W'(line) * ADDR_W'(w_use) +
             ADDR_W'(n_mbx) * ADDR_W'(MB_DIM) + ADDR_W'(n_bx) * ADDR_W'(BLK_DIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      height_q <= '0;
      fbase    <= '0;
      row      <= '0;
      bx       <= '0;
      by       <= '0;
      mbx      <= '0;
      mby      <= '0;
      addr     <= '0;
    end else begin
      if (clear) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
      end
      if (clear || frame_next || inc) begin
        fbase <= n_fbase;
        row   <= n_row;
        bx    <= n_bx;
        by    <= n_by;
        mbx   <= n_mbx;
        mby   <= n_mby;
        addr  <= n_addr;
      end
    end
  end

endmodule

// File: rtl/h264_feed_sched.sv
// Fetches raw frame words one at a time and hands them to the encoder in
// macroblock / 4x4-block / row order, one outstanding read at a time.
module h264_feed_sched
  import h264_feed_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int FRM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [11:0]       cfg_width,
  input  logic [11:0]       cfg_height,
  input  logic [FRM_W-1:0]  cfg_frames,
  // Handshakes: a read is issued when rd_req && rd_gnt on a rising edge, and its
  // data is taken on the edge where rd_rvalid is high. A word reaches the encoder on
  // the edge where enc_valid && enc_fetch_req; rd_addr / enc_data hold until then.
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_rvalid,
  input  logic [31:0]       rd_rdata,
  output logic              enc_valid,
  output logic [31:0]       enc_data,
  input  logic              enc_fetch_req,
  input  logic              enc_last4x4,
  output logic              busy,
  output logic              cfg_err,
  output logic [FRM_W-1:0]  frame_idx,
  output logic              irq,
  input  logic              irq_clr,
  output logic [2:0]        fsm_state
);

  state_t           state;
  logic [FRM_W-1:0] frames_q;
  logic             cfg_ok, start_ok, frame_last, last_word;
  logic             gen_inc, gen_frame_next;

  assign fsm_state  = state;
  assign cfg_ok     = dim_ok(cfg_width) && dim_ok(cfg_height) && (cfg_frames != '0);
  assign start_ok   = ((state == S_IDLE) || (state == S_DONE)) && cfg_start && cfg_ok;
  assign frame_last = (frame_idx + FRM_W'(1)) == frames_q;

  // Abort wins over a same-cycle transfer, so counters only move when not aborting.
  assign gen_inc        = (state == S_PUSH) && enc_fetch_req && !cfg_abort;
  assign gen_frame_next = (state == S_FLUSH) && enc_last4x4 && !cfg_abort && !frame_last;

  h264_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .inc        (gen_inc),
    .frame_next (gen_frame_next),
    .cfg_base   (cfg_base),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .last_word  (last_word),
    .addr       (rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_req    <= 1'b0;
      enc_valid <= 1'b0;
      enc_data  <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      frame_idx <= '0;
      frames_q  <= '0;
      irq       <= 1'b0;
    end else begin
      // Placed first so a same-cycle DONE entry below overrides the clear.
      if (irq_clr) irq <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (cfg_start) begin
            if (cfg_ok) begin
              state     <= S_REQ;
              rd_req    <= 1'b1;
              busy      <= 1'b1;
              cfg_err   <= 1'b0;
              frame_idx <= '0;
              frames_q  <= cfg_frames;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (cfg_abort) begin
            state  <= S_IDLE;
            rd_req <= 1'b0;
            busy   <= 1'b0;
          end else if (rd_gnt) begin
            state  <= S_WAIT;
            rd_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rd_rvalid) begin
            if (cfg_abort) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= S_PUSH;
              enc_valid <= 1'b1;
              enc_data  <= rd_rdata;
            end
          end else if (cfg_abort) begin
            state <= S_DRAIN;
          end
        end
        S_PUSH: begin
          if (cfg_abort) begin
            state     <= S_IDLE;
            enc_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (enc_fetch_req) begin
            enc_valid <= 1'b0;
            if (last_word) begin
              state <= S_FLUSH;
            end else begin
              state  <= S_REQ;
              rd_req <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (cfg_abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (enc_last4x4) begin
            frame_idx <= frame_idx + FRM_W'(1);
            if (frame_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              irq   <= 1'b1;
            end else begin
              state  <= S_REQ;
              rd_req <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (rd_rvalid) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rd_req    <= 1'b0;
          enc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
